// File: rtl/button_sw_conditioner.sv
// rtl/button_sw_conditioner.sv - per-key sync, debounce, press pulse and hold-to-repeat for button_sw
module button_sw_conditioner #(
  parameter int                N_KEYS          = 12,
  parameter int                DEBOUNCE_CYCLES = 200000,
  parameter int                HOLD_CYCLES     = 25000000,
  parameter int                REPEAT_CYCLES   = 5000000,
  parameter logic [N_KEYS-1:0] REPEAT_MASK     = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] button_sw,
  output logic [N_KEYS-1:0] button_sw_level,
  output logic [N_KEYS-1:0] button_sw_oneshot,
  output logic              any_pressed
);

  localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int DW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW       = $clog2(HOLD_MAX);

  localparam logic [DW-1:0] D_TERM = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_TERM = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] R_TERM = HW'(REPEAT_CYCLES - 1);

  logic [N_KEYS-1:0] stable_nxt;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    logic          s1;
    logic          s2;
    logic          stable;
    logic          pulse;
    logic          rep_phase;
    logic          rep_fire;
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt;

    // A new level is accepted only after DEBOUNCE_CYCLES consecutive mismatches
    assign stable_nxt[i] = (s2 != stable && dcnt == D_TERM) ? s2 : stable;

    assign rep_fire = REPEAT_MASK[i] && stable &&
                      (rep_phase ? (hcnt == R_TERM) : (hcnt == H_TERM));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        s1        <= 1'b0;
        s2        <= 1'b0;
        stable    <= 1'b0;
        dcnt      <= '0;
        hcnt      <= '0;
        rep_phase <= 1'b0;
        pulse     <= 1'b0;
      end else begin
        s1     <= button_sw[i];
        s2     <= s1;
        stable <= stable_nxt[i];

        if (s2 == stable || dcnt == D_TERM) dcnt <= '0;
        else                                dcnt <= dcnt + 1'b1;

        pulse <= (stable_nxt[i] & ~stable) | rep_fire;

        // Hold timer only runs on repeat-enabled keys while the debounced level is high
        if (!REPEAT_MASK[i] || !stable) begin
          hcnt      <= '0;
          rep_phase <= 1'b0;
        end else if (rep_fire) begin
          hcnt      <= '0;
          rep_phase <= 1'b1;
        end else begin
          hcnt <= hcnt + 1'b1;
        end
      end
    end

    assign button_sw_level[i]   = stable;
    assign button_sw_oneshot[i] = pulse;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) any_pressed <= 1'b0;
    else      any_pressed <= |stable_nxt;
  end

endmodule
